// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants for the pipe_stage_chain block: legal stage range and default widths.
package pipe_stage_chain_pkg;

   localparam int unsigned StagesMin = 2;
   localparam int unsigned StagesMax = 8;
   localparam int unsigned DefDataW  = 64;
   localparam int unsigned DefCntW   = 16;

endpackage

// File: rtl/pipe_stage_chain_reg.sv
// pipe_stage_reg: one valid+data pipeline stage. Priority is clear, then hold, then load.
module pipe_stage_reg
   import pipe_stage_chain_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              hold_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              validQ, validD;
   logic [DATA_W-1:0] dataQ, dataD;

   always_comb begin
      validD = validQ;
      dataD  = dataQ;
      if (clear_i) begin
         validD = 1'b0;
         dataD  = '0;
      end else if (!hold_i) begin
         // Bubbles arrive here as a load of valid=0, data=0.
         validD = valid_i;
         dataD  = data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         validQ <= 1'b0;
         dataQ  <= '0;
      end else begin
         validQ <= validD;
         dataQ  <= dataD;
      end
   end

   assign valid_o = validQ;
   assign data_o  = dataQ;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep valid/data pipeline with per-stage stall (holds upstream too),
// per-stage flush, occupancy count and a saturating stall-cycle counter.
module pipe_stage_chain
   import pipe_stage_chain_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned STAGES = 4,
   parameter int unsigned CNT_W  = DefCntW
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         in_ready,
   input  logic [STAGES-1:0]            stall,
   input  logic [STAGES-1:0]            flush,
   output logic [STAGES-1:0]            stage_valid,
   output logic [STAGES*DATA_W-1:0]     stage_data,
   output logic                         out_valid,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(STAGES+1)-1:0]  occupancy,
   output logic [CNT_W-1:0]             stall_cycles
);

   localparam int unsigned OccW = $clog2(STAGES + 1);

   if (STAGES < StagesMin || STAGES > StagesMax) begin : gen_bad_stages
      $error("pipe_stage_chain: STAGES outside legal range");
   end

   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] srcValid;
   logic [DATA_W-1:0] srcData [STAGES];

   // A stall at stage j holds every stage at or upstream of j.
   for (genvar i = 0; i < STAGES; i++) begin : gen_hold
      assign hold[i] = |stall[STAGES-1:i];
   end

   assign in_ready = ~hold[0];

   for (genvar i = 0; i < STAGES; i++) begin : gen_stage
      if (i == 0) begin : gen_head
         assign srcValid[i] = in_valid;
         assign srcData[i]  = in_valid ? in_data : '0;
      end else begin : gen_body
         // Upstream held but this stage free: insert a bubble.
         assign srcValid[i] = hold[i-1] ? 1'b0 : stage_valid[i-1];
         assign srcData[i]  = hold[i-1] ? '0 : stage_data[(i-1)*DATA_W +: DATA_W];
      end

      pipe_stage_reg #(
         .DATA_W(DATA_W)
      ) u_stage (
         .clk_i  (clk),
         .rst_ni (reset),
         .clear_i(flush[i]),
         .hold_i (hold[i]),
         .valid_i(srcValid[i]),
         .data_i (srcData[i]),
         .valid_o(stage_valid[i]),
         .data_o (stage_data[i*DATA_W +: DATA_W])
      );
   end

   assign out_valid = stage_valid[STAGES-1];
   assign out_data  = stage_data[(STAGES-1)*DATA_W +: DATA_W];

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < STAGES; i++) begin
         occupancy = occupancy + OccW'(stage_valid[i]);
      end
   end

   logic [CNT_W-1:0] stallCntQ, stallCntD;

   always_comb begin
      stallCntD = stallCntQ;
      if ((|stall) && !(&stallCntQ)) begin
         stallCntD = stallCntQ + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stallCntQ <= '0;
      end else begin
         stallCntQ <= stallCntD;
      end
   end

   assign stall_cycles = stallCntQ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (STAGES=4, DATA_W=8, CNT_W=4) with an output scoreboard.
module tb_pipe_stage_chain;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic [3:0]  stall = '0;
   logic [3:0]  flush = '0;
   logic [3:0]  stage_valid;
   logic [31:0] stage_data;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  occupancy;
   logic [3:0]  stall_cycles;

   int          nVec = 0;
   int          nMis = 0;
   int          peak = 0;
   logic [7:0]  sbQ[$];
   logic        lastLoad = 1'b0;

   pipe_stage_chain #(
      .DATA_W(8),
      .STAGES(4),
      .CNT_W (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .stall       (stall),
      .flush       (flush),
      .stage_valid (stage_valid),
      .stage_data  (stage_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .occupancy   (occupancy),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
   endtask

   task automatic fillPipe(input logic [7:0] base);
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = base + 8'(k);
         sbQ.push_back(in_data);
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic doReset();
      reset = 1'b0;
      sbQ.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   // A new word reaches the output only on an edge where the last stage was not held.
   always @(posedge clk) lastLoad = reset && !stall[3];

   always @(negedge clk) begin
      if (lastLoad && out_valid) begin
         if (sbQ.size() == 0) checkVal("sb_unexpected_word", 64'(sbQ.size()), 64'd1);
         else checkVal("out_data", 64'(out_data), 64'(sbQ.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t, limit 200000", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset state
      #3;
      checkVal("rst_out_valid", 64'(out_valid), 64'd0);
      checkVal("rst_out_data", 64'(out_data), 64'd0);
      checkVal("rst_occupancy", 64'(occupancy), 64'd0);
      checkVal("rst_stage_valid", 64'(stage_valid), 64'd0);
      checkVal("rst_stall_cycles", 64'(stall_cycles), 64'd0);
      checkVal("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Three-word stream, latency and occupancy peak
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h11 * (k + 1));
         sbQ.push_back(in_data);
         tick();
         if (int'(occupancy) > peak) peak = int'(occupancy);
      end
      in_valid = 1'b0;
      in_data  = '0;
      checkVal("lat_edge3_out_valid", 64'(out_valid), 64'd0);
      tick();
      checkVal("lat_edge4_out_valid", 64'(out_valid), 64'd1);
      repeat (4) begin
         if (int'(occupancy) > peak) peak = int'(occupancy);
         tick();
      end
      checkVal("occ_peak", 64'(peak), 64'd3);
      checkVal("occ_empty", 64'(occupancy), 64'd0);
      checkVal("sb_left_stream", 64'(sbQ.size()), 64'd0);

      // Mid-stage stall: stages 0-1 frozen, bubbles into stage 2
      fillPipe(8'hA0);
      stall    = 4'b0010;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      #1;
      checkVal("stall_in_ready_c1", 64'(in_ready), 64'd0);
      tick();
      checkVal("stall_in_ready_c2", 64'(in_ready), 64'd0);
      tick();
      checkVal("stall_stage_valid", 64'(stage_valid), 64'b0011);
      checkVal("stall_frozen_data", 64'(stage_data[15:0]), 64'hA2A3);
      checkVal("stall_bubble_data", 64'(stage_data[23:16]), 64'd0);
      checkVal("stall_cycles_2", 64'(stall_cycles), 64'd2);
      stall    = '0;
      in_valid = 1'b0;
      in_data  = '0;
      #1;
      checkVal("stall_release_ready", 64'(in_ready), 64'd1);
      drain(5);
      checkVal("stall_cycles_kept", 64'(stall_cycles), 64'd2);
      checkVal("sb_left_stall", 64'(sbQ.size()), 64'd0);

      // Flush stages 0-1 while stage 0 stalls; flush wins, stages 2-3 advance
      fillPipe(8'hB0);
      flush = 4'b0011;
      stall = 4'b0001;
      void'(sbQ.pop_back());
      tick();
      flush = '0;
      stall = '0;
      checkVal("flush_stage_valid", 64'(stage_valid), 64'b1100);
      checkVal("flush_cleared_data", 64'(stage_data[15:0]), 64'd0);
      checkVal("flush_advanced_data", 64'(stage_data[31:16]), 64'hB1B2);
      checkVal("flush_stall_cycles", 64'(stall_cycles), 64'd3);
      drain(4);
      checkVal("sb_left_flush", 64'(sbQ.size()), 64'd0);

      // Last-stage stall freezes everything
      fillPipe(8'hC0);
      stall    = 4'b1000;
      in_valid = 1'b1;
      in_data  = 8'hDD;
      #1;
      checkVal("freeze_in_ready", 64'(in_ready), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkVal("freeze_out_valid", 64'(out_valid), 64'd1);
         checkVal("freeze_out_data", 64'(out_data), 64'hC0);
         checkVal("freeze_occupancy", 64'(occupancy), 64'd4);
      end
      stall    = '0;
      in_valid = 1'b0;
      in_data  = '0;
      checkVal("freeze_stall_cycles", 64'(stall_cycles), 64'd6);
      drain(5);
      checkVal("sb_left_freeze", 64'(sbQ.size()), 64'd0);

      // Stall counter saturation at 15
      doReset();
      checkVal("sat_start", 64'(stall_cycles), 64'd0);
      stall = 4'b0001;
      drain(14);
      checkVal("sat_14", 64'(stall_cycles), 64'd14);
      drain(6);
      checkVal("sat_20", 64'(stall_cycles), 64'd15);
      drain(2);
      checkVal("sat_hold", 64'(stall_cycles), 64'd15);
      stall = '0;

      // Asynchronous reset mid-stream while stalled and flushing
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 8'hD1 + 8'(k);
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
      checkVal("mid_occupancy", 64'(occupancy), 64'd3);
      stall = 4'b0010;
      flush = 4'b0100;
      tick();
      reset = 1'b0;
      #1;
      checkVal("arst_out_valid", 64'(out_valid), 64'd0);
      checkVal("arst_out_data", 64'(out_data), 64'd0);
      checkVal("arst_occupancy", 64'(occupancy), 64'd0);
      checkVal("arst_stage_valid", 64'(stage_valid), 64'd0);
      checkVal("arst_stage_data", 64'(stage_data), 64'd0);
      checkVal("arst_stall_cycles", 64'(stall_cycles), 64'd0);
      sbQ.delete();
      stall = '0;
      flush = '0;
      @(posedge clk);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      sbQ.push_back(in_data);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      checkVal("post_rst_occupancy", 64'(occupancy), 64'd1);
      drain(2);
      checkVal("post_rst_edge3", 64'(out_valid), 64'd0);
      tick();
      checkVal("post_rst_edge4", 64'(out_valid), 64'd1);
      drain(3);
      checkVal("sb_left_post_rst", 64'(sbQ.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the payload width per stage in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the number of pipeline stages; legal range is 2..8.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the stall-cycle counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the payload on in_data is a real instruction/data word.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: payload entering stage 0.
REQ-008 The block SHALL have port in_ready, output, 1 bit: stage 0 accepts input this cycle.
REQ-009 The block SHALL have port stall, input, STAGES bits: bit i holds stage i and all upstream stages.
REQ-010 The block SHALL have port flush, input, STAGES bits: bit i invalidates stage i at the next edge.
REQ-011 The block SHALL have port stage_valid, output, STAGES bits: the current valid bit of each stage.
REQ-012 The block SHALL have port stage_data, output, STAGES*DATA_W bits: all stage payloads, with stage i in bits [i*DATA_W +: DATA_W], for forwarding logic.
REQ-013 The block SHALL have port out_valid and out_data, output, 1 and DATA_W bits: equal to stage_valid[STAGES-1] and the stage STAGES-1 payload.
REQ-014 The block SHALL have port occupancy, output, $clog2(STAGES+1) bits: the count of set stage_valid bits.
REQ-015 The block SHALL have port stall_cycles, output, CNT_W bits: a saturating count of clock edges on which any stall bit was set.

Function
REQ-016 hold[i] SHALL equal the OR of stall[j] for all j >= i (combinational).
REQ-017 in_ready SHALL equal NOT hold[0].
REQ-018 At each edge, stage i SHALL apply the first matching rule: flush[i] -> valid 0, data 0; hold[i] -> keep valid and data; i>0 and hold[i-1] -> bubble (valid 0, data 0); otherwise -> copy stage i-1 (i>0) or the input (i=0).
REQ-019 Stage 0 loading SHALL store valid = in_valid and data = in_data when in_valid=1, and data = 0 when in_valid=0.
REQ-020 Latency SHALL be STAGES cycles from acceptance to out_valid when no stall or flush occurs; throughput SHALL be one word per cycle.
REQ-021 flush SHALL win over stall on the same stage; flushing a held stage SHALL leave its upstream stages held.
REQ-022 Several flush bits asserted together SHALL clear all the named stages in the same edge.
REQ-023 stall[STAGES-1] SHALL freeze the whole chain and keep out_valid/out_data stable.
REQ-024 occupancy SHALL be combinational from stage_valid and range 0..STAGES.
REQ-025 stall_cycles SHALL increment by 1 on each edge with |stall=1 and hold at 2^CNT_W-1 with no wrap.

Reset
REQ-026 While reset=0, all stage valid bits, all stage data, and stall_cycles SHALL be 0 asynchronously; consequently out_valid=0, occupancy=0, out_data=0.
REQ-027 Reset asserted mid-stall or mid-flush SHALL discard all in-flight words; the first edge after reset release SHALL behave as an empty pipe.

Structure
REQ-028 A shared package SHALL hold the STAGES legal-range constants and the default DATA_W/CNT_W values.
REQ-029 One sub-module, pipe_stage_reg, SHALL implement a single valid+data stage with load/hold/clear controls; pipe_stage_chain SHALL instantiate it STAGES times via generate.

Verification (STAGES=4, DATA_W=8)
REQ-030 Feed 0x11,0x22,0x33 on consecutive cycles, no stall -> out_data 0x11,0x22,0x33 on cycles 4,5,6 with out_valid=1, and occupancy peaks at 3.
REQ-031 Full pipe (0xA0..0xA3), stall=4'b0010 for 2 cycles -> stages 0-1 frozen, stage 2 receives 2 bubbles, in_ready=0 for 2 cycles, stall_cycles=2.
REQ-032 Full pipe, flush=4'b0011 together with stall=4'b0001 -> stages 0-1 become valid 0 and data 0x00, and stages 2-3 advance normally.
REQ-033 stall=4'b1000 held 3 cycles with in_valid=1 -> out_data constant, no input accepted, occupancy unchanged.
REQ-034 CNT_W=4, stall held 20 cycles -> stall_cycles=15 and stays 15.
REQ-035 Assert reset low mid-stream with occupancy=3 -> all outputs 0 immediately; after release, word 0x5A appears at the output 4 cycles after acceptance.
